// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings, HLT opcode, reset PC.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  OPC_HLT      = 4'hF;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Architectural PC register: 16-bit, load enable, async active-low reset to RESET_PC.
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RESET_PC;
        else if (en) q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request, one-entry stall buffer, IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [3:0]  HALT_OPCODE = OPC_HLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_next_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        imem_rdy_i,
    input  logic [15:0] imem_data_i,
    output logic        imem_req_o,
    output logic [15:0] pc_o,
    output logic        ifid_valid_o,
    output logic [15:0] ifid_instr_o,
    output logic [15:0] ifid_pc_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] perf_fetch_o,
    output logic [15:0] perf_stall_o,
`endif
    output logic        halted_o
);

    fetch_state_t state, state_nxt;
    logic [15:0]  buf_q;
    logic [15:0]  word;
    logic         acc;
    logic         is_hlt;
    logic         pc_en;
    logic         capture;

    always_comb begin
        word      = (state == HOLD) ? buf_q : imem_data_i;
        acc       = (((state == FETCH) && imem_rdy_i) || (state == HOLD)) && !stall_i;
        is_hlt    = (word[15:12] == HALT_OPCODE);
        capture   = (state == FETCH) && imem_rdy_i && stall_i && !flush_i;
        // A HLT freezes the PC so a later wrong-path flush can redirect cleanly.
        pc_en     = flush_i || (acc && !is_hlt);
        state_nxt = state;
        if (flush_i)     state_nxt = FETCH;
        else if (acc)    state_nxt = is_hlt ? HALTED : FETCH;
        else if (capture) state_nxt = HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       buf_q <= 16'h0000;
        else if (capture) buf_q <= imem_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= 16'h0000;
            ifid_pc_o    <= 16'h0000;
        end else begin
            if (acc) begin
                ifid_instr_o <= word;
                ifid_pc_o    <= pc_o;
            end
            if (flush_i)  ifid_valid_o <= 1'b0;
            else if (acc) ifid_valid_o <= 1'b1;
        end
    end

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_next_i),
        .q     (pc_o)
    );

    // Request is suppressed while reset is asserted even though state sits in FETCH.
    assign imem_req_o = rst_n && (state == FETCH);
    assign halted_o   = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_o <= 16'h0000;
            perf_stall_o <= 16'h0000;
        end else begin
            if (acc && !flush_i && (perf_fetch_o != 16'hFFFF))
                perf_fetch_o <= perf_fetch_o + 16'd1;
            if (stall_i && (state != HALTED) && (perf_stall_o != 16'hFFFF))
                perf_stall_o <= perf_stall_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a behavioural model, plus directed literal checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_next_i;
    logic        stall_i, flush_i, imem_rdy_i;
    logic [15:0] imem_data_i;
    logic        imem_req_o, ifid_valid_o, halted_o;
    logic [15:0] pc_o, ifid_instr_o, ifid_pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_o, perf_stall_o;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_next_i    (pc_next_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .imem_rdy_i   (imem_rdy_i),
        .imem_data_i  (imem_data_i),
        .imem_req_o   (imem_req_o),
        .pc_o         (pc_o),
        .ifid_valid_o (ifid_valid_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc_o    (ifid_pc_o),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_o (perf_fetch_o),
        .perf_stall_o (perf_stall_o),
`endif
        .halted_o     (halted_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model: architectural view only (PC, IF/ID contents, halted flag, pending word queue).
    logic [15:0] m_pc, m_instr, m_ipc, m_pf, m_ps;
    bit          m_valid, m_halted;
    logic [15:0] m_buf[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
        m_valid = 0; m_halted = 0; m_pf = 0; m_ps = 0;
        m_buf.delete();
    endtask

    task automatic model_step();
        bit fetching, have, acc, was_halted;
        logic [15:0] w;
        was_halted = m_halted;
        fetching = !m_halted && (m_buf.size() == 0);
        have = fetching ? imem_rdy_i : (m_buf.size() != 0);
        w = fetching ? imem_data_i : (m_buf.size() != 0 ? m_buf[0] : 16'h0000);
        acc = have && !stall_i && !m_halted;
        if (acc) begin m_instr = w; m_ipc = m_pc; end
        if (acc && !flush_i && m_pf != 16'hFFFF) m_pf++;
        if (stall_i && !was_halted && m_ps != 16'hFFFF) m_ps++;
        if (flush_i) begin
            m_pc = pc_next_i; m_valid = 0; m_halted = 0; m_buf.delete();
        end else if (acc) begin
            m_valid = 1; m_buf.delete();
            if (w[15:12] == 4'hF) m_halted = 1;
            else m_pc = pc_next_i;
        end else if (fetching && imem_rdy_i && stall_i) begin
            m_buf.push_back(imem_data_i);
        end
    endtask

    // Advance one clock: model follows the same edge as the DUT.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc_o, m_pc);
            chk("req", {15'd0, imem_req_o}, {15'd0, rst_n && !m_halted && m_buf.size() == 0});
            chk("valid", {15'd0, ifid_valid_o}, {15'd0, m_valid});
            chk("instr", ifid_instr_o, m_instr);
            chk("ifid_pc", ifid_pc_o, m_ipc);
            chk("halted", {15'd0, halted_o}, {15'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_o, m_pf);
            chk("perf_stall", perf_stall_o, m_ps);
`endif
        end
    end

    task automatic drive(input bit rdy, input bit st, input bit fl,
                         input logic [15:0] d, input logic [15:0] nx);
        imem_rdy_i = rdy; stall_i = st; flush_i = fl; imem_data_i = d; pc_next_i = nx;
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 16'h0000, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_req", {15'd0, imem_req_o}, 16'd0);
        chk("rst_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("rst_instr", ifid_instr_o, 16'h0000);
        chk("rst_ifid_pc", ifid_pc_o, 16'h0000);
        chk("rst_halted", {15'd0, halted_o}, 16'd0);
        rst_n = 1;
        chk_en = 1;
        #1 chk("req_after_rst", {15'd0, imem_req_o}, 16'd1);

        // Back-to-back fetch
        drive(1, 0, 0, 16'h1234, 16'h0002); step();
        chk("t1_ipc0", ifid_pc_o, 16'h0000);
        chk("t1_instr0", ifid_instr_o, 16'h1234);
        chk("t1_valid", {15'd0, ifid_valid_o}, 16'd1);
        drive(1, 0, 0, 16'h5678, 16'h0004); step();
        chk("t1_ipc1", ifid_pc_o, 16'h0002);
        chk("t1_instr1", ifid_instr_o, 16'h5678);
        chk("t1_pc", pc_o, 16'h0004);

        // Stall with capture into HOLD
        drive(1, 1, 0, 16'hABCD, 16'h0006); step();
        chk("t2_req_hold", {15'd0, imem_req_o}, 16'd0);
        chk("t2_instr_hold", ifid_instr_o, 16'h5678);
        drive(0, 1, 0, 16'h0000, 16'h0006); step(); step();
        chk("t2_pc_hold", pc_o, 16'h0004);
        drive(0, 0, 0, 16'h0000, 16'h0006); step();
        chk("t2_instr", ifid_instr_o, 16'hABCD);
        chk("t2_ipc", ifid_pc_o, 16'h0004);
        chk("t2_pc", pc_o, 16'h0006);

        // Flush while stalled in HOLD
        drive(1, 1, 0, 16'h1111, 16'h0008); step();
        drive(0, 1, 1, 16'h0000, 16'h0040); step();
        chk("t3_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("t3_pc", pc_o, 16'h0040);
        chk("t3_req", {15'd0, imem_req_o}, 16'd1);
        drive(1, 0, 0, 16'h2222, 16'h0042); step();
        chk("t3_instr", ifid_instr_o, 16'h2222);
        chk("t3_ipc", ifid_pc_o, 16'h0040);

        // HLT at 0x0010
        drive(0, 0, 1, 16'h0000, 16'h0010); step();
        drive(1, 0, 0, 16'hF000, 16'h0012); step();
        chk("t4_valid", {15'd0, ifid_valid_o}, 16'd1);
        chk("t4_halted", {15'd0, halted_o}, 16'd1);
        chk("t4_req", {15'd0, imem_req_o}, 16'd0);
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                  16'($urandom), 16'($urandom));
            step();
        end
        chk("t4_pc_frozen", pc_o, 16'h0010);
        chk("t4_still_halted", {15'd0, halted_o}, 16'd1);

        // Wrong-path HLT recovery
        drive(0, 0, 1, 16'h0000, 16'h0100); step();
        chk("t5_halted", {15'd0, halted_o}, 16'd0);
        chk("t5_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("t5_req", {15'd0, imem_req_o}, 16'd1);
        chk("t5_pc", pc_o, 16'h0100);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d, nx;
            d = 16'($urandom);
            if ($urandom_range(0, 9) == 0) d[15:12] = 4'hF;
            case ($urandom_range(0, 15))
                0:       nx = 16'($urandom);
                1:       nx = 16'hFFFE;
                2:       nx = m_pc + 16'd1;
                default: nx = m_pc + 16'd2;
            endcase
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 11) == 0, d, nx);
            step();
        end

        // Async reset mid-fetch with no response pending
        drive(0, 0, 0, 16'h0000, 16'h0000); step(); step();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("t6_pc", pc_o, 16'h0000);
        chk("t6_req", {15'd0, imem_req_o}, 16'd0);
        chk("t6_valid", {15'd0, ifid_valid_o}, 16'd0);
        chk("t6_instr", ifid_instr_o, 16'h0000);
        chk("t6_ipc", ifid_pc_o, 16'h0000);
        chk("t6_halted", {15'd0, halted_o}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_pf", perf_fetch_o, 16'h0000);
        chk("t6_ps", perf_stall_o, 16'h0000);
`endif
        @(posedge clk); #1 rst_n = 1;
        drive(1, 0, 0, 16'h3333, 16'h0002); step();
        chk("t6_restart_ipc", ifid_pc_o, 16'h0000);
        chk("t6_restart_instr", ifid_instr_o, 16'h3333);
        chk("t6_restart_pc", pc_o, 16'h0002);
        step();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
